// File: rtl/execute_pipe.sv
// Pipelined execute stage: ALU, branch/jump resolution, registered EX/MEM output with handshake.
// Define EXECUTE_MULT_EN to add the iterative multiplier with HI/LO and the MUL state.
module execute_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_STEPS = DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [25:0]       i_imm,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    input  logic              i_ALUSrc,
    input  logic [1:0]        i_ALUop,
    input  logic              i_extOp,
    input  logic              i_jump,
    input  logic              i_beq,
    input  logic              i_bne,
    input  logic              i_mult,
    input  logic              i_mfhi,
    input  logic              i_mflo,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_ALUres,
    output logic [DATA_W-1:0] o_op2,
    output logic [DATA_W-1:0] o_nextPC,
    output logic              o_pcsrc,
    output logic              o_busy
);

    localparam logic [DATA_W-1:0] PcStep = DATA_W'(4);

    logic [15:0]       imm16;
    logic [DATA_W-1:0] ext_imm, alu_b, alu_res, res_sel;
    logic [DATA_W-1:0] pc4, branch_tgt, jump_tgt, next_pc;
    logic              zero, pcsrc;
    logic              idle, accept, accept_alu, mul_done;
    logic [DATA_W-1:0] mul_lo;

    logic              valid_q, pcsrc_q;
    logic [DATA_W-1:0] alures_q, op2_q, nextpc_q;

    assign imm16   = i_imm[15:0];
    assign ext_imm = i_extOp ? {{(DATA_W-16){imm16[15]}}, imm16} : {{(DATA_W-16){1'b0}}, imm16};
    assign alu_b   = i_ALUSrc ? ext_imm : i_op2;

    always_comb begin
        alu_res = '0;
        case (i_ALUop)
            2'b00: alu_res = i_op1 + alu_b;
            2'b01: alu_res = i_op1 - alu_b;
            2'b11: alu_res = i_op1 | alu_b;
            default: begin
                case (i_imm[5:0])
                    6'b100000: alu_res = i_op1 + alu_b;
                    6'b100010: alu_res = i_op1 - alu_b;
                    6'b100100: alu_res = i_op1 & alu_b;
                    6'b100101: alu_res = i_op1 | alu_b;
                    6'b100111: alu_res = ~(i_op1 | alu_b);
                    6'b101010: alu_res = {{(DATA_W-1){1'b0}}, $signed(i_op1) < $signed(alu_b)};
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

    // zero is taken from the raw ALU result, before HI/LO substitution
    assign zero       = (alu_res == '0);
    assign pc4        = i_pc + PcStep;
    assign branch_tgt = pc4 + {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
    assign jump_tgt   = {pc4[DATA_W-1:28], i_imm, 2'b00};
    assign pcsrc      = i_jump | (i_beq & zero) | (i_bne & ~zero);
    assign next_pc    = i_jump ? jump_tgt : branch_tgt;

    assign o_ready = idle & (~valid_q | i_ready);
    assign accept  = i_valid & o_ready & ~i_flush;

`ifdef EXECUTE_MULT_EN
    localparam int unsigned CntW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    typedef enum logic {StIdle, StMul} state_e;
    state_e state_q, state_d;

    logic [2*DATA_W-1:0] mcand_q, acc_q, acc_step;
    logic [DATA_W-1:0]   mplr_q, hi_q, lo_q;
    logic [CntW-1:0]     cnt_q;
    logic                mul_start, mul_last;

    assign idle       = (state_q == StIdle);
    assign o_busy     = (state_q == StMul);
    assign mul_start  = accept & i_mult;
    assign accept_alu = accept & ~i_mult;
    assign mul_last   = (state_q == StMul) && (cnt_q == CntW'(MUL_STEPS - 1));
    assign mul_done   = mul_last & ~i_flush;
    assign acc_step   = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign mul_lo     = acc_step[DATA_W-1:0];
    assign res_sel    = i_mfhi ? hi_q : (i_mflo ? lo_q : alu_res);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (i_flush || mul_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                mcand_q <= {{DATA_W{1'b0}}, i_op1};
                mplr_q  <= i_op2;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == StMul && !i_flush) begin
                acc_q   <= acc_step;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
                cnt_q   <= cnt_q + 1'b1;
                if (mul_last) {hi_q, lo_q} <= acc_step;
            end
        end
    end
`else
    logic unused_mult;

    assign unused_mult = i_mult;
    assign idle        = 1'b1;
    assign o_busy      = 1'b0;
    assign accept_alu  = accept;
    assign mul_done    = 1'b0;
    assign mul_lo      = '0;
    assign res_sel     = (i_mfhi | i_mflo) ? '0 : alu_res;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            pcsrc_q  <= 1'b0;
            alures_q <= '0;
            op2_q    <= '0;
            nextpc_q <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
            pcsrc_q <= 1'b0;
        end else if (accept_alu) begin
            valid_q  <= 1'b1;
            pcsrc_q  <= pcsrc;
            alures_q <= res_sel;
            op2_q    <= i_op2;
            nextpc_q <= next_pc;
        end else if (mul_done) begin
            valid_q  <= 1'b1;
            pcsrc_q  <= 1'b0;
            alures_q <= mul_lo;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid  = valid_q;
    assign o_pcsrc  = pcsrc_q;
    assign o_ALUres = alures_q;
    assign o_op2    = op2_q;
    assign o_nextPC = nextpc_q;

endmodule
